pulse_stretch: RTL and testbench

PULSE_STRETCH -- requirements
Module: pulse_stretch

---
 rtl/pulse_pkg.sv | 12 +
 rtl/load_downcnt.sv | 26 ++
 rtl/pulse_stretch.sv | 99 +++++++++
 tb/tb_pulse_stretch.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse stretcher.
//   state_t    : FSM state encoding (IDLE / HOLD / GUARD)
//   CNT_W_DEF  : default width of the length input and hold counter
package pulse_pkg;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_GUARD = 2'd2
  } state_t;
endpackage

// File: rtl/load_downcnt.sv
// Loadable saturating down-counter.
//   clk, rst_n : clock, async active-low reset (count -> 0)
//   load       : load load_val (has priority over en)
//   load_val   : value to load
//   en         : decrement by one; holds at zero, never wraps
//   zero       : count is zero
module load_downcnt #(
  parameter int W = pulse_pkg::CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/pulse_stretch.sv
// Pulse stretcher: turns a single-cycle trig into a level held high for
// len cycles, followed by GAP mandatory low (guard) cycles.
//   clk, rst_n : clock, async active-low reset
//   trig       : single-cycle request
//   len        : requested high duration, sampled on an accepted trig
//   retrig_en  : 1 = trig during HOLD reloads the hold counter
//   level      : stretched output
//   busy       : state != IDLE
//   done       : one-cycle strobe in the first cycle after level falls
//   drop       : one-cycle strobe the cycle after an ignored trig
module pulse_stretch import pulse_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig,
  input  logic [CNT_W-1:0] len,
  input  logic             retrig_en,
  output logic             level,
  output logic             busy,
  output logic             done,
  output logic             drop
);
  // The done cycle is the first guard cycle, so the guard counter starts at GAP-1.
  localparam logic [7:0] GUARD_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  state_t     state;
  logic [7:0] gcnt;
  logic       len_ok, accept, retrig, zero;

  assign len_ok = (len != '0);
  assign accept = (state == S_IDLE) && trig && len_ok;
  assign retrig = (state == S_HOLD) && trig && retrig_en && len_ok;

  // Counter holds len-1 in the first high cycle, so zero marks the last one.
  load_downcnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept | retrig),
    .load_val (len - CNT_W'(1)),
    .en       (state == S_HOLD),
    .zero     (zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      gcnt  <= '0;
      level <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      drop  <= 1'b0;
    end else begin
      done <= 1'b0;
      drop <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trig) begin
            if (len_ok) begin
              state <= S_HOLD;
              level <= 1'b1;
              busy  <= 1'b1;
            end else begin
              drop <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          // A retrigger wins over expiry: level simply stays high.
          if (!retrig) begin
            if (trig) drop <= 1'b1;
            if (zero) begin
              level <= 1'b0;
              done  <= 1'b1;
              if (GAP > 0) begin
                state <= S_GUARD;
                gcnt  <= GUARD_LAST;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
        S_GUARD: begin
          if (trig) drop <= 1'b1;
          if (gcnt == 8'd0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gcnt <= gcnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: two instances (GAP=2 and GAP=0) share stimulus;
// a reference model tracks, per instance, the absolute cycle of the last
// high cycle and of the last guard cycle, and derives outputs from those.
module tb_pulse_stretch;
  logic       clk = 1'b0, rst_n = 1'b0, trig = 1'b0, retrig_en = 1'b0;
  logic [7:0] len = 8'd0;
  logic lvl_a, busy_a, done_a, drop_a;
  logic lvl_b, busy_b, done_b, drop_b;

  pulse_stretch #(.CNT_W(8), .GAP(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .trig(trig), .len(len), .retrig_en(retrig_en),
    .level(lvl_a), .busy(busy_a), .done(done_a), .drop(drop_a));
  pulse_stretch #(.CNT_W(8), .GAP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .trig(trig), .len(len), .retrig_en(retrig_en),
    .level(lvl_b), .busy(busy_b), .done(done_b), .drop(drop_b));

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0, failures = 0;
  int hold_end[2], guard_end[2];
  logic [3:0] exp_v[2];   // {level, busy, done, drop} expected for the current cycle

  function automatic int gap_of(int g);
    return (g == 0) ? 2 : 0;
  endfunction

  // Edge e ends cycle e; computes what cycle e+1 should show.
  task automatic model_edge(int g);
    int e;
    bit in_hold, in_guard;
    logic dp;
    e = cyc;
    dp = 1'b0;
    if (!rst_n) begin
      hold_end[g] = -1000; guard_end[g] = -1000; exp_v[g] = 4'b0;
      return;
    end
    in_hold  = (e <= hold_end[g]);
    in_guard = !in_hold && (e <= guard_end[g]);
    if (trig) begin
      if (in_hold) begin
        if (retrig_en && len != 0) hold_end[g] = e + int'(len);
        else dp = 1'b1;
      end else if (in_guard) dp = 1'b1;
      else if (len != 0) hold_end[g] = e + int'(len);
      else dp = 1'b1;
      guard_end[g] = hold_end[g] + gap_of(g);
    end
    exp_v[g] = {(e + 1 <= hold_end[g]), (e + 1 <= guard_end[g]), (e == hold_end[g]), dp};
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; trig = 1'b1; len = 8'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({lvl_a, busy_a, done_a, drop_a, lvl_b, busy_b, done_b, drop_b} !== 8'b0) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got=%b want=00000000", cyc,
                 {lvl_a, busy_a, done_a, drop_a, lvl_b, busy_b, done_b, drop_b});
      end
    end
    trig = 1'b0;
    #2 rst_n = 1'b1;
    // first edge after release must accept a trig
    trig = 1'b1; len = 8'd3;
    tick();
    trig = 1'b0;
    checks++;
    if ({lvl_a, busy_a, lvl_b, busy_b} !== 4'b1111) begin
      failures++;
      $display("FAIL first_trig got=%b want=1111", {lvl_a, busy_a, lvl_b, busy_b});
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({lvl_a, busy_a, done_a, drop_a, lvl_b, busy_b, done_b, drop_b} !== {exp_v[0], exp_v[1]}) begin
        failures++;
        $display("FAIL first_trig_seq cyc=%0d got=%b want=%b", cyc,
                 {lvl_a, busy_a, done_a, drop_a, lvl_b, busy_b, done_b, drop_b}, {exp_v[0], exp_v[1]});
      end
    end
  endtask

  task automatic test_basic();
    int hi = 0, bz = 0, dn = 0;
    retrig_en = 1'b0;
    for (int i = 0; i < 14; i++) begin
      trig = (i == 0);
      len  = (i == 0) ? 8'd5 : 8'd2;   // len changes during HOLD must be ignored
      tick();
      hi += int'(lvl_a); bz += int'(busy_a); dn += int'(done_a);
      checks++;
      if ({lvl_a, busy_a, done_a, drop_a, lvl_b, busy_b, done_b, drop_b} !== {exp_v[0], exp_v[1]}) begin
        failures++;
        $display("FAIL basic cyc=%0d got=%b want=%b", cyc,
                 {lvl_a, busy_a, done_a, drop_a, lvl_b, busy_b, done_b, drop_b}, {exp_v[0], exp_v[1]});
      end
      if (i == 5) begin
        checks++;
        if (done_a !== 1'b1) begin failures++; $display("FAIL basic_done_pos got=%b want=1", done_a); end
      end
    end
    trig = 1'b0;
    checks++;
    if (hi != 5 || bz != 7 || dn != 1) begin
      failures++;
      $display("FAIL basic_counts got hi=%0d busy=%0d done=%0d want 5 7 1", hi, bz, dn);
    end
  endtask

  task automatic test_retrig();
    for (int s = 0; s < 2; s++) begin
      int hi = 0, dn = 0, dp = 0;
      retrig_en = 1'b1;
      for (int i = 0; i < 14; i++) begin
        // s=0: retrigger mid-hold; s=1: retrigger on the final hold cycle
        trig = (s == 0) ? (i == 0 || i == 2) : (i == 0 || i == 3);
        len  = (s == 0) ? 8'd4 : 8'd3;
        tick();
        hi += int'(lvl_a); dn += int'(done_a); dp += int'(drop_a);
        checks++;
        if ({lvl_a, busy_a, done_a, drop_a, lvl_b, busy_b, done_b, drop_b} !== {exp_v[0], exp_v[1]}) begin
          failures++;
          $display("FAIL retrig%0d cyc=%0d got=%b want=%b", s, cyc,
                   {lvl_a, busy_a, done_a, drop_a, lvl_b, busy_b, done_b, drop_b}, {exp_v[0], exp_v[1]});
        end
      end
      trig = 1'b0;
      checks++;
      if (hi != 6 || dn != 1 || dp != 0) begin
        failures++;
        $display("FAIL retrig%0d_counts got hi=%0d done=%0d drop=%0d want 6 1 0", s, hi, dn, dp);
      end
    end
  endtask

  task automatic test_drops();
    int hi = 0, dn = 0, dp = 0;
    retrig_en = 1'b0; len = 8'd4;
    for (int i = 0; i < 16; i++) begin
      trig = (i == 0 || i == 2 || i == 6);
      tick();
      hi += int'(lvl_a); dn += int'(done_a); dp += int'(drop_a);
      checks++;
      if ({lvl_a, busy_a, done_a, drop_a, lvl_b, busy_b, done_b, drop_b} !== {exp_v[0], exp_v[1]}) begin
        failures++;
        $display("FAIL drops cyc=%0d got=%b want=%b", cyc,
                 {lvl_a, busy_a, done_a, drop_a, lvl_b, busy_b, done_b, drop_b}, {exp_v[0], exp_v[1]});
      end
    end
    trig = 1'b0;
    checks++;
    if (hi != 4 || dn != 1 || dp != 2) begin
      failures++;
      $display("FAIL drops_counts got hi=%0d done=%0d drop=%0d want 4 1 2", hi, dn, dp);
    end
  endtask

  task automatic test_boundary();
    int hi = 0, dn = 0, dp = 0, hib = 0, dnb = 0;
    retrig_en = 1'b0;
    // len = 0: drop only
    for (int i = 0; i < 4; i++) begin
      trig = (i == 0); len = 8'd0;
      tick();
      hi += int'(lvl_a) + int'(lvl_b); dp += int'(drop_a);
      checks++;
      if ({lvl_a, busy_a, done_a, drop_a, lvl_b, busy_b, done_b, drop_b} !== {exp_v[0], exp_v[1]}) begin
        failures++;
        $display("FAIL len0 cyc=%0d got=%b want=%b", cyc,
                 {lvl_a, busy_a, done_a, drop_a, lvl_b, busy_b, done_b, drop_b}, {exp_v[0], exp_v[1]});
      end
    end
    checks++;
    if (hi != 0 || dp != 1) begin
      failures++;
      $display("FAIL len0_counts got hi=%0d drop=%0d want 0 1", hi, dp);
    end
    // len = 255: maximum hold
    hi = 0; dn = 0;
    for (int i = 0; i < 262; i++) begin
      trig = (i == 0); len = 8'd255;
      tick();
      hi += int'(lvl_a); dn += int'(done_a);
      checks++;
      if ({lvl_a, busy_a, done_a, drop_a, lvl_b, busy_b, done_b, drop_b} !== {exp_v[0], exp_v[1]}) begin
        failures++;
        $display("FAIL len255 cyc=%0d got=%b want=%b", cyc,
                 {lvl_a, busy_a, done_a, drop_a, lvl_b, busy_b, done_b, drop_b}, {exp_v[0], exp_v[1]});
      end
    end
    checks++;
    if (hi != 255 || dn != 1) begin
      failures++;
      $display("FAIL len255_counts got hi=%0d done=%0d want 255 1", hi, dn);
    end
    // GAP=0 instance: trig on its done cycle is accepted at once
    hi = 0; dp = 0;
    for (int i = 0; i < 12; i++) begin
      trig = (i == 0 || i == 4); len = 8'd3;
      tick();
      hib += int'(lvl_b); dnb += int'(done_b); dp += int'(drop_a);
      checks++;
      if ({lvl_a, busy_a, done_a, drop_a, lvl_b, busy_b, done_b, drop_b} !== {exp_v[0], exp_v[1]}) begin
        failures++;
        $display("FAIL gap0 cyc=%0d got=%b want=%b", cyc,
                 {lvl_a, busy_a, done_a, drop_a, lvl_b, busy_b, done_b, drop_b}, {exp_v[0], exp_v[1]});
      end
      if (i == 4) begin
        checks++;
        if (lvl_b !== 1'b1) begin failures++; $display("FAIL gap0_b2b level got=%b want=1", lvl_b); end
      end
    end
    trig = 1'b0;
    checks++;
    if (hib != 6 || dnb != 2 || dp != 1) begin
      failures++;
      $display("FAIL gap0_counts got hi_b=%0d done_b=%0d drop_a=%0d want 6 2 1", hib, dnb, dp);
    end
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    retrig_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      trig = (i == 0); len = 8'd8;
      tick();
    end
    trig = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({lvl_a, busy_a, done_a, lvl_b, busy_b, done_b} !== 6'b0) begin
      failures++;
      $display("FAIL reset_mid_async got=%b want=000000",
               {lvl_a, busy_a, done_a, lvl_b, busy_b, done_b});
    end
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      dn += int'(done_a) + int'(done_b);
      checks++;
      if ({lvl_a, busy_a, done_a, drop_a, lvl_b, busy_b, done_b, drop_b} !== {exp_v[0], exp_v[1]}) begin
        failures++;
        $display("FAIL reset_mid cyc=%0d got=%b want=%b", cyc,
                 {lvl_a, busy_a, done_a, drop_a, lvl_b, busy_b, done_b, drop_b}, {exp_v[0], exp_v[1]});
      end
    end
    checks++;
    if (dn != 0) begin failures++; $display("FAIL reset_mid_no_done got=%0d want=0", dn); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      trig      = ($urandom_range(0, 3) == 0);
      len       = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      retrig_en = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if ({lvl_a, busy_a, done_a, drop_a, lvl_b, busy_b, done_b, drop_b} !== {exp_v[0], exp_v[1]}) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b want=%b", cyc,
                 {lvl_a, busy_a, done_a, drop_a, lvl_b, busy_b, done_b, drop_b}, {exp_v[0], exp_v[1]});
      end
    end
    trig = 1'b0;
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      hold_end[g] = -1000; guard_end[g] = -1000; exp_v[g] = 4'b0;
    end
    test_reset();
    test_basic();
    test_retrig();
    test_drops();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
